// File: rtl/spi_tx_engine_if.sv
//----------------------------------------------------------------------------
// spi_tx_engine_if : request/serial bundle between a client and spi_tx_engine
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface spi_tx_engine_if #(
  parameter int DATA_W = 8
);
  logic              CPOL;
  logic              CPHA;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              tx_done;
  logic              SCLK;
  logic              MOSI;
  logic              CS_n;

  // master issues transfer requests; slave is the engine driving the SPI pins
  modport master (
    output CPOL, CPHA, tx_data, tx_start,
    input  tx_busy, tx_done, SCLK, MOSI, CS_n
  );

  modport slave (
    input  CPOL, CPHA, tx_data, tx_start,
    output tx_busy, tx_done, SCLK, MOSI, CS_n
  );
endinterface

`default_nettype wire

// File: rtl/spi_tx_engine.sv
//----------------------------------------------------------------------------
// spi_tx_engine : SPI master transmit half, MSB-first, any CPOL/CPHA mode
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module spi_tx_engine #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  wire logic      clk_ext,
  input  wire logic      reset_n,
  spi_tx_engine_if.slave bus
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] C_EDGE_LAST = EDGE_W'(2 * DATA_W - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q,   div_d;
  logic [EDGE_W-1:0] edge_q,  edge_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cpol_q,  cpol_d;
  logic              cpha_q,  cpha_d;
  logic              sclk_q,  sclk_d;
  logic              mosi_q,  mosi_d;
  logic              cs_n_q,  cs_n_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              div_end;
  logic              launch;

  always_ff @(posedge clk_ext or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      shreg_q <= '0;
      cpol_q  <= 1'b1;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      shreg_q <= shreg_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    shreg_d = shreg_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    launch  = 1'b0;
    div_end = (div_q == C_DIV_LAST);

    unique case (state_q)
      S_IDLE: begin
        sclk_d = bus.CPOL;
        mosi_d = 1'b0;
        div_d  = '0;
        edge_d = '0;
        if (bus.tx_start) begin
          cpol_d  = bus.CPOL;
          cpha_d  = bus.CPHA;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
          // CPHA=0 presents the MSB before the first (sampling) edge
          if (!bus.CPHA) begin
            mosi_d  = bus.tx_data[DATA_W-1];
            shreg_d = bus.tx_data << 1;
          end else begin
            shreg_d = bus.tx_data;
          end
        end
      end

      S_SETUP: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d   = '0;
          edge_d  = '0;
          sclk_d  = ~sclk_q;
          state_d = S_SHIFT;
          launch  = cpha_q;
        end
      end

      S_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // edge_q counts edges taken inside SHIFT; edge number is edge_q+2
          if (cpha_q) begin
            launch = edge_q[0];
          end else begin
            launch = ~edge_q[0] && (edge_q != C_EDGE_LAST);
          end
          if (edge_q == C_EDGE_LAST) begin
            edge_d  = '0;
            state_d = S_HOLD;
          end else begin
            edge_d = edge_q + 1'b1;
          end
        end
      end

      S_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d   = '0;
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          sclk_d  = cpol_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (launch) begin
      mosi_d  = shreg_q[DATA_W-1];
      shreg_d = shreg_q << 1;
    end
  end

  assign bus.SCLK    = sclk_q;
  assign bus.MOSI    = mosi_q;
  assign bus.CS_n    = cs_n_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_engine.sv
//----------------------------------------------------------------------------
// tb_spi_tx_engine : directed bench for spi_tx_engine with a loopback receiver
// Revision 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_tx_engine;

  logic clk_ext = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  spi_tx_engine_if #(.DATA_W(8)) bus ();

  spi_tx_engine #(.DATA_W(8), .CLK_DIV(4)) dut (
    .clk_ext (clk_ext),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called at a negedge; tx_start is then sampled on the next posedge (T)
  task automatic kick(input logic cpol, input logic cpha, input logic [7:0] data, input bit settle);
    bus.CPOL = cpol;
    bus.CPHA = cpha;
    if (settle) begin
      repeat (2) @(negedge clk_ext);
      check("idle_sclk", 32'(bus.SCLK), 32'(cpol));
      check("idle_cs",   32'(bus.CS_n), 32'd1);
    end
    bus.tx_data  = data;
    bus.tx_start = 1'b1;
  endtask

  // follows one frame from cycle T+1, acting as the receive shifter
  task automatic watch(input logic cpol, input logic cpha, input int inject_n, input int toggle_n,
                       input bit chain, input logic [7:0] next_data,
                       output logic [7:0] rx_buffer, output int edges, output int done_n,
                       output int cs_low, output int busy_n, output int bad_mosi,
                       output logic first_cs, output logic done_cs);
    logic prev_sclk, prev_mosi, sample_edge;
    rx_buffer = '0; edges = 0; done_n = -1; cs_low = 0; busy_n = 0; bad_mosi = 0;
    done_cs = 1'b0;
    prev_sclk = cpol;
    prev_mosi = bus.MOSI;
    @(negedge clk_ext);
    bus.tx_start = 1'b0;
    first_cs = bus.CS_n;
    for (int n = 1; n <= 200; n++) begin
      sample_edge = 1'b0;
      if (bus.SCLK !== prev_sclk) begin
        edges++;
        sample_edge = (prev_sclk == cpol) ^ cpha;
        if (sample_edge) rx_buffer = {rx_buffer[6:0], prev_mosi};
      end
      if (n > 1 && !bus.tx_done && bus.MOSI !== prev_mosi &&
          !(bus.SCLK !== prev_sclk && !sample_edge)) bad_mosi++;
      if (!bus.CS_n) cs_low++;
      if (bus.tx_busy) busy_n++;
      if (bus.tx_done) begin
        done_n   = n;
        done_cs  = bus.CS_n;
        bus.CPOL = cpol;
        bus.CPHA = cpha;
        if (chain) begin
          bus.tx_data  = next_data;
          bus.tx_start = 1'b1;
        end
        break;
      end
      if (n == inject_n) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h00;
      end else if (n == inject_n + 1) begin
        bus.tx_start = 1'b0;
      end
      if (n == toggle_n) begin
        bus.CPOL    = ~bus.CPOL;
        bus.CPHA    = ~bus.CPHA;
        bus.tx_data = ~bus.tx_data;
      end
      prev_sclk = bus.SCLK;
      prev_mosi = bus.MOSI;
      @(negedge clk_ext);
    end
  endtask

  task automatic run_frame(input string id, input logic cpol, input logic cpha,
                           input logic [7:0] data, input bit do_kick, input int inject_n,
                           input int toggle_n, input bit chain, input logic [7:0] next_data);
    logic [7:0] rx_buffer;
    int   edges, done_n, cs_low, busy_n, bad_mosi;
    logic first_cs, done_cs;
    if (do_kick) kick(cpol, cpha, data, 1'b1);
    watch(cpol, cpha, inject_n, toggle_n, chain, next_data,
          rx_buffer, edges, done_n, cs_low, busy_n, bad_mosi, first_cs, done_cs);
    check({id, "_rx"},       32'(rx_buffer), 32'(data));
    check({id, "_edges"},    32'(edges),     32'd16);
    check({id, "_done_at"},  32'(done_n),    32'd69);
    check({id, "_cs_low"},   32'(cs_low),    32'd68);
    check({id, "_busy"},     32'(busy_n),    32'd68);
    check({id, "_mosi_chg"}, 32'(bad_mosi),  32'd0);
    check({id, "_cs_first"}, 32'(first_cs),  32'd0);
    check({id, "_cs_done"},  32'(done_cs),   32'd1);
    if (!chain) begin
      @(negedge clk_ext);
      check({id, "_done_pulse"}, 32'(bus.tx_done), 32'd0);
      check({id, "_post_sclk"},  32'(bus.SCLK),    32'(cpol));
      check({id, "_post_mosi"},  32'(bus.MOSI),    32'd0);
      check({id, "_post_cs"},    32'(bus.CS_n),    32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    bus.CPOL = 1'b1; bus.CPHA = 1'b0; bus.tx_data = '0; bus.tx_start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_sclk", 32'(bus.SCLK),    32'd1);
    check("rst_mosi", 32'(bus.MOSI),    32'd0);
    check("rst_cs",   32'(bus.CS_n),    32'd1);
    check("rst_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_done", 32'(bus.tx_done), 32'd0);
    repeat (3) @(negedge clk_ext);
    reset_n = 1'b1;
    @(negedge clk_ext);

    run_frame("t1", 1'b1, 1'b0, 8'hB5, 1'b1, -10, -10, 1'b0, 8'h00);
    run_frame("t2", 1'b0, 1'b0, 8'h3C, 1'b1, -10, -10, 1'b0, 8'h00);
    run_frame("t3", 1'b1, 1'b1, 8'hA5, 1'b1, -10, -10, 1'b0, 8'h00);
    run_frame("t4a", 1'b0, 1'b1, 8'h96, 1'b1, 20, -10, 1'b1, 8'h5A);
    run_frame("t4b", 1'b0, 1'b1, 8'h5A, 1'b0, -10, -10, 1'b0, 8'h00);

    // reset lands mid-frame at T+30
    kick(1'b1, 1'b0, 8'hB5, 1'b1);
    @(negedge clk_ext);
    bus.tx_start = 1'b0;
    repeat (29) @(negedge clk_ext);
    reset_n = 1'b0;
    #1;
    check("abort_cs",   32'(bus.CS_n),    32'd1);
    check("abort_sclk", 32'(bus.SCLK),    32'd1);
    check("abort_mosi", 32'(bus.MOSI),    32'd0);
    check("abort_busy", 32'(bus.tx_busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_ext);
      if (i == 2) reset_n = 1'b1;
      if (bus.tx_done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_frame("t5", 1'b1, 1'b0, 8'hC3, 1'b1, -10, -10, 1'b0, 8'h00);

    run_frame("t6", 1'b1, 1'b0, 8'hB5, 1'b1, -10, 30, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
